// File: rtl/nic_core.sv
// nic8 processor core: one-byte instructions, DW-wide datapath, AW-wide PC,
// memory behind a req/ack handshake that tolerates wait states.
module nic_core #(
   parameter int DW = 8,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          reset,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   output logic          halted,
   output logic [AW-1:0] pc
);

   typedef enum logic [1:0] {ST_RUN, ST_MEM, ST_HALT} state_e;
   typedef enum logic [1:0] {S_MEM, S_ALU, S_A, S_X} src_e;
   typedef enum logic [2:0] {D_IR, D_PC, D_A, D_X, D_B, D_ST, D_OUT, D_HALT} dst_e;

   state_e        state_q;
   logic [AW-1:0] pc_q, pc_d, addr_q, addr;
   logic [DW-1:0] a_q, a_d, b_q, b_d, x_q, x_d;
   logic [7:0]    ir_q, ir_d;
   logic          carry_q, carry_d;
   logic [DW-1:0] out_data_q, wdata_q;
   logic          out_valid_q, req_q, we_q, halted_q;

   logic          b7, b6, idx, zero, cond, taken, is_halt, mem_step, commit;
   src_e          src;
   dst_e          dst;
   logic [DW:0]   alu;
   logic [DW-1:0] src_val;

   always_comb begin
      b7  = ir_q[7];
      b6  = ir_q[6];
      src = src_e'(ir_q[5:4]);
      dst = dst_e'(ir_q[3:1]);
      idx = ir_q[0];

      addr = idx ? x_q[AW-1:0] : pc_q;
      // Subtract is A + ~B + 1, so the carry out reads as "no borrow".
      alu  = {1'b0, a_q} + {1'b0, (b7 ? ~b_q : b_q)} + {{DW{1'b0}}, b7};

      case (src)
         S_MEM:   src_val = mem_rdata;
         S_ALU:   src_val = alu[DW-1:0];
         S_A:     src_val = a_q;
         default: src_val = x_q;
      endcase

      zero = (a_q == '0);
      case ({b7, b6})
         2'b11:   cond = 1'b1;
         2'b10:   cond = zero;
         2'b01:   cond = carry_q;
         default: cond = 1'b0;
      endcase
      taken = (dst == D_PC) && cond;

      is_halt  = (dst == D_HALT);
      mem_step = (src == S_MEM) || (dst == D_IR) || (dst == D_ST);
      commit   = ((state_q == ST_RUN) && !is_halt && !mem_step) ||
                 ((state_q == ST_MEM) && mem_ack);

      pc_d    = taken ? src_val[AW-1:0] : (idx ? pc_q : pc_q + AW'(1));
      ir_d    = (dst == D_IR) ? mem_rdata[7:0] : '0;
      a_d     = (dst == D_A) ? src_val : a_q;
      x_d     = (dst == D_X) ? src_val : x_q;
      b_d     = (dst == D_B) ? src_val : b_q;
      carry_d = (src == S_ALU) ? alu[DW] : carry_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_RUN;
         pc_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         x_q         <= '0;
         ir_q        <= '0;
         carry_q     <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         halted_q    <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (commit) begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            x_q     <= x_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            if (dst == D_OUT) begin
               out_data_q  <= src_val;
               out_valid_q <= 1'b1;
            end
         end
         case (state_q)
            ST_RUN: begin
               if (is_halt) begin
                  state_q  <= ST_HALT;
                  halted_q <= 1'b1;
               end else if (mem_step) begin
                  req_q   <= 1'b1;
                  addr_q  <= addr;
                  we_q    <= (dst == D_ST) && (src != S_MEM);
                  wdata_q <= src_val;
                  state_q <= ST_MEM;
               end
            end
            ST_MEM: begin
               if (mem_ack) begin
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  state_q <= ST_RUN;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign halted    = halted_q;
   assign pc        = pc_q;

endmodule

// File: tb/tb_nic_core.sv
// Bench for nic_core: directed programs plus random programs, each checked
// against an instruction-level reference interpreter of the nic8 ISA.
module tb_nic_core;

   logic clk    = 1'b0;
   logic reset  = 1'b1;
   logic wreset = 1'b1;
   always #5 clk = ~clk;

   logic       mem_req, mem_we, out_valid, halted;
   logic       mem_ack = 1'b0;
   logic [7:0] mem_addr, mem_wdata, mem_rdata, out_data, pc;
   logic [7:0] mem [256];
   assign mem_rdata = mem[mem_addr];

   nic_core #(.DW(8), .AW(8)) u_dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .out_data(out_data), .out_valid(out_valid),
      .halted(halted), .pc(pc)
   );

   // Wide instance: zero-wait memory, ack follows request directly.
   logic        w_req, w_we, w_ov, w_halt;
   logic [7:0]  w_addr, w_pc;
   logic [15:0] w_wdata, w_rdata, w_out;
   logic [15:0] wmem [256];
   assign w_rdata = wmem[w_addr];

   nic_core #(.DW(16), .AW(8)) u_wide (
      .clk(clk), .reset(wreset), .mem_req(w_req), .mem_we(w_we),
      .mem_addr(w_addr), .mem_wdata(w_wdata), .mem_ack(w_req),
      .mem_rdata(w_rdata), .out_data(w_out), .out_valid(w_ov),
      .halted(w_halt), .pc(w_pc)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Memory responder with configurable wait states.
   int fixed_wait = 0;
   int max_wait   = 0;
   int wcnt = 0, wtarget = 0;
   always @(negedge clk) begin
      if (!mem_req) begin
         mem_ack = 1'b0;
         wcnt    = 0;
         wtarget = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, max_wait));
      end else if (wcnt >= wtarget) begin
         mem_ack = 1'b1;
      end else begin
         mem_ack = 1'b0;
         wcnt++;
      end
   end

   int wr_cnt = 0;
   always @(posedge clk) begin
      if (mem_req && mem_ack && mem_we && !reset) begin
         mem[mem_addr] = mem_wdata;
         wr_cnt++;
      end
   end

   // Monitors: request stability while waiting, outputs, requests after halt.
   logic       hold = 1'b0, s_we;
   logic [7:0] s_addr, s_wd;
   int         stab_err = 0, halt_req = 0;
   logic [7:0] out_q [$];
   logic [15:0] wout_q [$];
   always @(posedge clk) begin
      hold   = mem_req && !mem_ack && !reset;
      s_addr = mem_addr;
      s_we   = mem_we;
      s_wd   = mem_wdata;
   end
   always @(negedge clk) begin
      if (hold && !reset)
         if (!mem_req || mem_addr !== s_addr || mem_we !== s_we || (s_we && mem_wdata !== s_wd))
            stab_err++;
      if (out_valid) out_q.push_back(out_data);
      if (halted && mem_req) halt_req++;
      if (w_ov) wout_q.push_back(w_out);
   end

   // Reference interpreter: executes IR against its own copy of memory.
   logic [7:0] rmem [256];
   logic [7:0] exp_q [$];
   logic [7:0] exp_pc;
   int         exp_wr;

   task automatic model_run();
      logic [7:0] p, a, b, x, ir, addr, val, r, nir;
      logic       c, cout, taken;
      p = 0; a = 0; b = 0; x = 0; ir = 0; c = 0;
      exp_q.delete();
      exp_wr = 0;
      for (int s = 0; s < 5000; s++) begin
         if (ir[3:1] == 3'd7) break;
         addr = ir[0] ? x : p;
         if (ir[7]) begin
            r = a - b;
            cout = (a >= b);
         end else begin
            r = a + b;
            cout = (int'(a) + int'(b)) > 255;
         end
         case (ir[5:4])
            2'd0:    val = rmem[addr];
            2'd1:    val = r;
            2'd2:    val = a;
            default: val = x;
         endcase
         taken = 1'b0;
         nir   = 8'h00;
         case (ir[3:1])
            3'd0: nir = rmem[addr];
            3'd1: taken = (ir[7] && ir[6]) || (ir[7] && !ir[6] && a == 0) || (!ir[7] && ir[6] && c);
            3'd2: a = val;
            3'd3: x = val;
            3'd4: b = val;
            3'd5: if (ir[5:4] != 2'd0) begin rmem[addr] = val; exp_wr++; end
            3'd6: exp_q.push_back(val);
            default: ;
         endcase
         if (ir[5:4] == 2'd1) c = cout;
         if (taken) p = val;
         else if (!ir[0]) p = p + 8'd1;
         ir = nir;
      end
      exp_pc = p;
   endtask

   task automatic fill_mem(input logic [7:0] v);
      for (int i = 0; i < 256; i++) mem[i] = v;
   endtask

   task automatic put_bytes(input int base, input logic [127:0] bytes, input int n);
      for (int i = 0; i < n; i++) mem[base + i] = bytes[8*(n-1-i) +: 8];
   endtask

   task automatic run_prog(input string name, input int mw, input int fw);
      int d;
      max_wait = mw;
      fixed_wait = fw;
      for (int i = 0; i < 256; i++) rmem[i] = mem[i];
      model_run();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      out_q.delete();
      wr_cnt = 0; stab_err = 0; halt_req = 0;
      reset = 1'b0;
      for (int c = 0; c < 4000 && !halted; c++) @(negedge clk);
      repeat (4) @(negedge clk);
      check_eq({name, "_halted"}, 32'(halted), 32'd1);
      check_eq({name, "_pc"}, 32'(pc), 32'(exp_pc));
      check_eq({name, "_nout"}, out_q.size(), exp_q.size());
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
         check_eq({name, "_out"}, 32'(out_q[i]), 32'(exp_q[i]));
      d = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== rmem[i]) d++;
      check_eq({name, "_memdiff"}, d, 0);
      check_eq({name, "_writes"}, wr_cnt, exp_wr);
      check_eq({name, "_stable"}, stab_err, 0);
      check_eq({name, "_req_after_halt"}, halt_req, 0);
   endtask

   // Straight-line random program with forward-only jumps; X stays in 0xC0..0xFF.
   task automatic gen_random();
      logic [7:0] op [40];
      logic [7:0] opd [40];
      bit         hasop [40];
      bit         isjmp [40];
      int         at [41];
      int         n, k;
      logic [7:0] hb;
      for (int i = 0; i < 256; i++) mem[i] = (i >= 192) ? 8'($urandom) : 8'h0E;
      n = int'($urandom_range(6, 30));
      for (int i = 0; i < n; i++) begin
         hb = 8'($urandom_range(0, 1)) << 7;
         hasop[i] = 1'b0; isjmp[i] = 1'b0; opd[i] = 8'h00;
         k = (i == 0) ? 2 : int'($urandom_range(0, 11));
         case (k)
            0:  begin op[i] = 8'h04; hasop[i] = 1; opd[i] = 8'($urandom); end
            1:  begin op[i] = 8'h08; hasop[i] = 1; opd[i] = 8'($urandom); end
            2:  begin op[i] = 8'h06; hasop[i] = 1; opd[i] = 8'hC0 | 8'($urandom_range(0, 63)); end
            3:  op[i] = 8'h05;
            4:  op[i] = 8'h09;
            5:  op[i] = 8'h15 | hb;
            6:  op[i] = 8'h29;
            7:  op[i] = 8'h1D | hb;
            8:  case ($urandom_range(0, 2)) 0: op[i] = 8'h2D; 1: op[i] = 8'h3D; default: op[i] = 8'h0D; endcase
            9:  op[i] = $urandom_range(0, 1) ? 8'h2B : (8'h1B | hb);
            10: begin op[i] = 8'h02 | (8'($urandom_range(0, 3)) << 6); hasop[i] = 1; isjmp[i] = 1; end
            default: op[i] = 8'h19 | hb;
         endcase
      end
      at[0] = 0;
      for (int i = 0; i < n; i++) at[i+1] = at[i] + 1 + int'(hasop[i]);
      for (int i = 0; i < n; i++) begin
         mem[at[i]] = op[i];
         if (hasop[i])
            mem[at[i] + 1] = isjmp[i] ? 8'(at[$urandom_range(i + 1, n)]) : opd[i];
      end
   endtask

   initial begin
      int w0;
      // Wide program: A=FFFF, B=1, A+=B (carry, zero), jumps on C and Z, out A, X=1234, jump via X, out X.
      for (int i = 0; i < 256; i++) wmem[i] = 16'h000E;
      wmem[0]  = 16'h0004; wmem[1]  = 16'hFFFF; wmem[2]  = 16'h0008; wmem[3]  = 16'h0001;
      wmem[4]  = 16'h0015; wmem[5]  = 16'h0042; wmem[6]  = 16'h0009;
      wmem[9]  = 16'h0082; wmem[10] = 16'h000C; wmem[12] = 16'h002D;
      wmem[13] = 16'h0006; wmem[14] = 16'h1234; wmem[15] = 16'h00F3;
      wmem[8'h34] = 16'h003D;

      fill_mem(8'h0E);
      put_bytes(0, 128'h0405_0803_1D0E, 6);
      fixed_wait = 0;
      repeat (2) @(negedge clk);
      check_eq("rst_pc", 32'(pc), 32'd0);
      check_eq("rst_req", 32'(mem_req), 32'd0);
      check_eq("rst_we", 32'(mem_we), 32'd0);
      check_eq("rst_addr", 32'(mem_addr), 32'd0);
      check_eq("rst_oval", 32'(out_valid), 32'd0);
      check_eq("rst_odata", 32'(out_data), 32'd0);
      check_eq("rst_halted", 32'(halted), 32'd0);
      reset = 1'b0;
      wreset = 1'b0;
      @(negedge clk);
      check_eq("fetch1_req", 32'(mem_req), 32'd1);
      check_eq("fetch1_addr", 32'(mem_addr), 32'd0);
      check_eq("fetch1_we", 32'(mem_we), 32'd0);
      @(negedge clk);
      check_eq("fetch2_pc", 32'(pc), 32'd1);

      for (w0 = 0; w0 < 500 && !w_halt; w0++) @(negedge clk);
      check_eq("wide_halted", 32'(w_halt), 32'd1);
      check_eq("wide_pc", 32'(w_pc), 32'h36);
      check_eq("wide_nout", wout_q.size(), 2);
      if (wout_q.size() == 2) begin
         check_eq("wide_out0", 32'(wout_q[0]), 32'h0000);
         check_eq("wide_out1", 32'(wout_q[1]), 32'h1234);
      end

      run_prog("add", 0, 0);
      check_eq("add_pc_spec", 32'(pc), 32'd6);
      check_eq("add_nout_spec", out_q.size(), 1);
      if (out_q.size() == 1) check_eq("add_out_spec", 32'(out_q[0]), 32'h08);

      run_prog("add_wait3", 0, 3);
      check_eq("addw_pc_spec", 32'(pc), 32'd6);

      fill_mem(8'h0E);
      put_bytes(0, 128'h0403_0805_9542_0A2D_0E, 9);
      run_prog("sub_borrow", 1, -1);
      check_eq("subb_pc_spec", 32'(pc), 32'd9);
      if (out_q.size() == 1) check_eq("subb_out_spec", 32'(out_q[0]), 32'hFE);

      fill_mem(8'h0E);
      put_bytes(0, 128'h0405_0803_9542_0A0E_0E0E_2D0E, 12);
      run_prog("sub_carry", 1, -1);
      check_eq("subc_pc_spec", 32'(pc), 32'd12);
      if (out_q.size() == 1) check_eq("subc_out_spec", 32'(out_q[0]), 32'h02);

      fill_mem(8'h0E);
      put_bytes(0, 128'h8240, 2);
      run_prog("jz_taken", 2, -1);
      check_eq("jzt_pc_spec", 32'(pc), 32'h41);

      fill_mem(8'h0E);
      put_bytes(0, 128'h0407_8240_0E, 5);
      run_prog("jz_not", 2, -1);
      check_eq("jzn_pc_spec", 32'(pc), 32'd5);

      fill_mem(8'h0E);
      put_bytes(0, 128'h06C0_045A_2B0E, 6);
      mem[8'hC0] = 8'h33;
      run_prog("store_wait3", 0, 3);
      check_eq("st_data_spec", 32'(mem[8'hC0]), 32'h5A);
      check_eq("st_writes_spec", wr_cnt, 1);

      // Reset while the store is waiting for ack.
      fill_mem(8'h0E);
      put_bytes(0, 128'h06C0_045A_2B0E, 6);
      mem[8'hC0] = 8'h33;
      fixed_wait = 3;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 100 && !(mem_req && mem_we); c++) @(negedge clk);
      check_eq("rmid_store_seen", 32'(mem_req && mem_we), 32'd1);
      #1 reset = 1'b1;
      #1;
      check_eq("rmid_req", 32'(mem_req), 32'd0);
      check_eq("rmid_pc", 32'(pc), 32'd0);
      repeat (2) @(negedge clk);
      check_eq("rmid_mem", 32'(mem[8'hC0]), 32'h33);
      reset = 1'b0;
      @(negedge clk);
      check_eq("rmid_refetch_req", 32'(mem_req), 32'd1);
      check_eq("rmid_refetch_addr", 32'(mem_addr), 32'd0);
      check_eq("rmid_refetch_we", 32'(mem_we), 32'd0);

      for (int t = 0; t < 40; t++) begin
         gen_random();
         run_prog("rnd", int'($urandom_range(0, 3)), -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nic_core.md
# nic_core

Parametrised, synthesizable nic8 processor core. It runs the nic8 one-byte instruction encoding with configurable data and address widths. Memory sits behind a req/ack handshake that tolerates wait states, replacing direct array access. Adds ALU subtract, a carry flag, zero/carry conditional jumps, halt, and an output strobe. It sits between the system memory model/ROM and the output display in the top-level system.

## Interface
- `DW`, 8: data width of A, B, X, ALU and data bus.
- `AW`, 8: address/PC width; must satisfy AW ≤ DW.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `mem_req`  out  1  memory transaction request (registered).
- `mem_we`  out  1  1 = write, 0 = read; valid while mem_req.
- `mem_addr`  out  AW  transaction address; valid while mem_req.
- `mem_wdata`  out  DW  write data; valid while mem_req && mem_we.
- `mem_ack`  in  1  transaction completes on an edge where mem_ack=1.
- `mem_rdata`  in  DW  read data; sampled on the ack edge.
- `out_data`  out  DW  last value written by an OUT step.
- `out_valid`  out  1  one-cycle pulse when out_data updates.
- `halted`  out  1  core stopped.
- `pc`  out  AW  program counter (debug/visibility).

## Operation
- **IR format:** IR[7:0] = {b7, b6, src[1:0], dst[2:0], idx}. When DW > 8, instruction fetch uses only mem_rdata[7:0].
- **Sources (`src`):**
  - 0 = memory
  - 1 = ALU
  - 2 = A
  - 3 = X
- **Destinations (`dst`):**
  - 0 = IR (fetch)
  - 1 = PC (jump)
  - 2 = A
  - 3 = X
  - 4 = B
  - 5 = store to memory
  - 6 = OUT
  - 7 = HALT
- **Address:** idx=0 (immediate) uses address = pc. idx=1 uses address = X[AW-1:0].
- **Commit rules:** every committed step except HALT and taken jumps sets pc ← pc+1 (mod 2^AW) when idx=0. IR ← fetched byte if dst=0, else IR ← 0. Opcode 0x00 is therefore "fetch next instruction".
- **ALU:**
  - b7=0: {c, r} = A + B.
  - b7=1: {c, r} = A + ~B + 1, so c=1 means no borrow.
  - r is DW bits wide.
  - carry ← c only when src=1 and the step commits; otherwise carry holds.
  - Z = (A == 0), evaluated combinationally from current A.
- **Jumps (dst=1):**
  - {b7,b6}=11: always taken.
  - 10: taken if Z.
  - 01: taken if carry.
  - 00: never taken.
  - Taken: pc ← source value [AW-1:0], with no increment.
  - Not taken: pc follows the normal immediate-increment rule. An immediate jump consumes its operand byte either way.
- **Memory steps:** src=0, dst=0, or dst=5.
  - src=0 with dst=5 performs the read only; no write is issued.
  - A store with src=0 never occurs.
- **FSM states:**
  - **RUN:** decode IR.
    - Non-memory step: commit this edge, stay in RUN.
    - Memory step: register mem_req=1 with addr/we/wdata, go to MEM.
    - dst=7: go to HALT, halted=1, pc unchanged.
  - **MEM:** hold mem_req, addr, we and wdata stable. On an edge with mem_ack=1, commit, drop mem_req, go to RUN.
  - **HALT:** absorbing until reset; no requests are issued.
- **OUT:** out_data ← source value, and out_valid=1 for exactly the following cycle.
- mem_ack is ignored outside MEM.
- **Reset values:** pc, A, B, X, IR, carry = 0. out_data = 0; out_valid, mem_req, mem_we, halted = 0; mem_addr = 0; state = RUN.
  - Reset asserted mid-MEM drops mem_req immediately and abandons the transaction; a pending write must not commit.

## Timing
- Non-memory step: 1 cycle.
- Memory step: 1 RUN cycle, then ≥1 MEM cycle, so 2 cycles minimum with same-cycle ack.
- First fetch after reset release: mem_req rises at edge 1, with addr 0.
  - With immediate ack, IR is loaded and pc=1 at edge 2.
- Register, carry and out_valid updates are visible in the cycle after the commit edge.
- A step reading A/B/X sees values committed by the previous step; there is no forwarding hazard.

## Test plan
- **Add and output:** DW=8, zero-wait memory, program 04 05 08 03 1D 0E → one out_valid pulse with out_data=0x08; halted=1; pc=6; no requests after halt.
- **Subtract and carry:** A=3, B=5, instruction 0x95 (A ← A−B) → A=0xFE, carry=0. Then A=5, B=3 → A=0x02, carry=1.
- **Conditional jumps:**
  - A=0, 0x82 with operand 0x40 → pc=0x40.
  - A≠0 → pc = operand address + 1.
  - 0x42 with carry=0 → not taken.
- **Wait states:** ack delayed 3 cycles → mem_req, mem_addr and mem_we are stable for all 4 MEM cycles; exactly one commit; a write to a store address lands once.
- **Reset mid-transaction:** reset asserted in MEM during a store → mem_req=0 asynchronously; pc=0; memory unchanged; a clean fetch at address 0 follows release.
- **Wide datapath:** DW=16, AW=8, A=0xFFFF, B=1, ALU add to A → A=0x0000, carry=1, Z=1. Jump via X=0x1234 → pc=0x34.
